// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch request/response, data request/response and shared
// memory port signals of the two-to-one memory arbiter.
//   slave  : the arbiter's view (requests and memory response in,
//            requester responses and memory request out)
//   master : the environment's view (core requesters plus memory model)
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // fetch requester
    logic                  ireq_valid;
    logic [ADDR_W-1:0]     ireq_addr;
    logic                  iresp_data_ok;
    logic [31:0]           iresp_data;
    // data requester
    logic                  dreq_valid;
    logic [ADDR_W-1:0]     dreq_addr;
    logic [2:0]            dreq_size;
    logic [DATA_W/8-1:0]   dreq_strobe;
    logic [DATA_W-1:0]     dreq_wdata;
    logic                  dresp_data_ok;
    logic [DATA_W-1:0]     dresp_data;
    // shared memory port
    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic [2:0]            mem_size;
    logic [DATA_W/8-1:0]   mem_strobe;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_data_ok, iresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        output dresp_data_ok, dresp_data,
        output mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata,
        input  mem_data_ok, mem_rdata
    );

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_data_ok, iresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        input  dresp_data_ok, dresp_data,
        input  mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata,
        output mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-fetch bus and the data bus.
// One transaction is outstanding at a time; the request is latched at the
// grant and held on mem_* until mem_data_ok. Simultaneous requests are
// resolved round-robin using the last granted requester.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : mem_arbiter_if.slave (requests, responses, memory port)
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    typedef enum logic {OWNER_I = 1'b0, OWNER_D = 1'b1} owner_t;

    state_t              state_reg,  state_next;
    owner_t              last_reg,   last_next;
    logic [ADDR_W-1:0]   addr_reg,   addr_next;
    logic [2:0]          size_reg,   size_next;
    logic [STRB_W-1:0]   strobe_reg, strobe_next;
    logic [DATA_W-1:0]   wdata_reg,  wdata_next;
    logic                grant_i;
    logic                grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            last_reg   <= OWNER_D;   // first conflict after reset goes to fetch
            addr_reg   <= '0;
            size_reg   <= '0;
            strobe_reg <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            last_reg   <= last_next;
            addr_reg   <= addr_next;
            size_reg   <= size_next;
            strobe_reg <= strobe_next;
            wdata_reg  <= wdata_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        last_next   = last_reg;
        addr_next   = addr_reg;
        size_next   = size_reg;
        strobe_next = strobe_reg;
        wdata_next  = wdata_reg;
        grant_i     = 1'b0;
        grant_d     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Fetch wins when alone, or on a conflict if data went last.
                // mem_data_ok is deliberately not looked at here.
                grant_i = bus.ireq_valid && (!bus.dreq_valid || last_reg == OWNER_D);
                grant_d = bus.dreq_valid && !grant_i;
                if (grant_i) begin
                    state_next  = BUSY_I;
                    last_next   = OWNER_I;
                    addr_next   = bus.ireq_addr;
                    size_next   = 3'b010;    // fetches are always 4 bytes
                    strobe_next = '0;
                    wdata_next  = '0;
                end else if (grant_d) begin
                    state_next  = BUSY_D;
                    last_next   = OWNER_D;
                    addr_next   = bus.dreq_addr;
                    size_next   = bus.dreq_size;
                    strobe_next = bus.dreq_strobe;
                    wdata_next  = bus.dreq_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port and responses. Read data is a plain pass-through; only the
    // owner's data_ok qualifies it.
    always_comb begin
        bus.mem_valid     = (state_reg != IDLE);
        bus.mem_addr      = addr_reg;
        bus.mem_size      = size_reg;
        bus.mem_strobe    = strobe_reg;
        bus.mem_wdata     = wdata_reg;
        bus.iresp_data_ok = (state_reg == BUSY_I) && bus.mem_data_ok;
        bus.dresp_data_ok = (state_reg == BUSY_D) && bus.mem_data_ok;
        bus.iresp_data    = bus.mem_rdata[31:0];
        bus.dresp_data    = bus.mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled 1 time unit later.
module tb_mem_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %0b expected 0", bus.mem_valid); end
        checks++; if (bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL reset_iresp_ok: got %0b expected 0", bus.iresp_data_ok); end
        checks++; if (bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL reset_dresp_ok: got %0b expected 0", bus.dresp_data_ok); end
        checks++; if (bus.mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_size !== 3'b000) begin errors++; $display("FAIL reset_mem_size: got %b expected 000", bus.mem_size); end
        checks++; if (bus.mem_strobe !== 8'h00 || bus.mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_mem_payload: got strobe %h wdata %h expected 0/0", bus.mem_strobe, bus.mem_wdata); end
        $display("reset: done");
    endtask

    task automatic test_fetch();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h0000_0000_8000_0000;
        #1;
        // grant cycle: request not yet on the memory port
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fetch_grant_cycle_valid: got %0b expected 0", bus.mem_valid); end
        tick();
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL fetch_mem_valid: got %0b expected 1", bus.mem_valid); end
        checks++; if (bus.mem_addr !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL fetch_mem_addr: got %h expected 80000000", bus.mem_addr); end
        checks++; if (bus.mem_size !== 3'b010) begin errors++; $display("FAIL fetch_mem_size: got %b expected 010", bus.mem_size); end
        checks++; if (bus.mem_strobe !== 8'h00 || bus.mem_wdata !== 64'h0) begin errors++; $display("FAIL fetch_mem_payload: got strobe %h wdata %h expected 0/0", bus.mem_strobe, bus.mem_wdata); end
        checks++; if (bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_early_ok: got %0b expected 0", bus.iresp_data_ok); end
        tick();
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 64'h0000_0000_0010_0093;
        bus.ireq_valid  = 1'b0;
        #1;
        // third cycle counting the request cycle
        checks++; if (bus.iresp_data_ok !== 1'b1) begin errors++; $display("FAIL fetch_data_ok: got %0b expected 1", bus.iresp_data_ok); end
        checks++; if (bus.iresp_data !== 32'h0010_0093) begin errors++; $display("FAIL fetch_data: got %h expected 00100093", bus.iresp_data); end
        checks++; if (bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_dresp_ok: got %0b expected 0", bus.dresp_data_ok); end
        tick();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        #1;
        checks++; if (bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %0b expected 0", bus.iresp_data_ok); end
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fetch_back_idle: got %0b expected 0", bus.mem_valid); end
        $display("fetch: addr 80000000 done");
    endtask

    task automatic test_data_write();
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h0000_0000_8000_1000;
        bus.dreq_size   = 3'b011;
        bus.dreq_strobe = 8'h0F;
        bus.dreq_wdata  = 64'h0000_0000_DEAD_BEEF;
        tick();
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL dwr_mem_valid: got %0b expected 1", bus.mem_valid); end
        checks++; if (bus.mem_addr !== 64'h0000_0000_8000_1000) begin errors++; $display("FAIL dwr_mem_addr: got %h expected 80001000", bus.mem_addr); end
        checks++; if (bus.mem_size !== 3'b011) begin errors++; $display("FAIL dwr_mem_size: got %b expected 011", bus.mem_size); end
        checks++; if (bus.mem_strobe !== 8'h0F) begin errors++; $display("FAIL dwr_mem_strobe: got %h expected 0f", bus.mem_strobe); end
        checks++; if (bus.mem_wdata !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL dwr_mem_wdata: got %h expected deadbeef", bus.mem_wdata); end
        tick();
        checks++; if (bus.iresp_data_ok !== 1'b0 || bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL dwr_wait_ok: got i=%0b d=%0b expected 0/0", bus.iresp_data_ok, bus.dresp_data_ok); end
        tick();
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 64'h1122_3344_5566_7788;
        bus.dreq_valid  = 1'b0;
        #1;
        checks++; if (bus.dresp_data_ok !== 1'b1) begin errors++; $display("FAIL dwr_data_ok: got %0b expected 1", bus.dresp_data_ok); end
        checks++; if (bus.dresp_data !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL dwr_dresp_data: got %h expected 1122334455667788", bus.dresp_data); end
        checks++; if (bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL dwr_iresp_ok: got %0b expected 0", bus.iresp_data_ok); end
        tick();
        bus.mem_data_ok = 1'b0;
        #1;
        checks++; if (bus.dresp_data_ok !== 1'b0 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL dwr_after: got d_ok=%0b valid=%0b expected 0/0", bus.dresp_data_ok, bus.mem_valid); end
        $display("data_write: addr 80001000 strobe 0f done");
    endtask

    task automatic test_round_robin();
        logic [63:0] exp_addr;
        logic        exp_i;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.ireq_valid  = 1'b1;
        bus.ireq_addr   = 64'h1000;
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h2000;
        bus.dreq_size   = 3'b011;
        bus.dreq_strobe = 8'h00;
        bus.dreq_wdata  = '0;
        for (int k = 0; k < 4; k++) begin
            exp_i    = (k % 2 == 0);
            exp_addr = exp_i ? 64'h1000 : 64'h2000;
            #1;
            checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_gap[%0d]: got %0b expected 0", k, bus.mem_valid); end
            tick();
            checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== exp_addr) begin errors++; $display("FAIL rr_grant[%0d]: got valid %0b addr %h expected 1 %h", k, bus.mem_valid, bus.mem_addr, exp_addr); end
            tick();
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = 64'(k);
            if (k == 3) begin
                bus.ireq_valid = 1'b0;
                bus.dreq_valid = 1'b0;
            end
            #1;
            checks++; if (bus.iresp_data_ok !== exp_i || bus.dresp_data_ok !== !exp_i) begin errors++; $display("FAIL rr_owner[%0d]: got i=%0b d=%0b expected i=%0b d=%0b", k, bus.iresp_data_ok, bus.dresp_data_ok, exp_i, !exp_i); end
            tick();
            bus.mem_data_ok = 1'b0;
            $display("round_robin: txn %0d expected %s", k, exp_i ? "I" : "D");
        end
    endtask

    task automatic test_payload_hold();
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h100;
        bus.dreq_strobe = 8'h00;
        tick();
        bus.dreq_addr = 64'h200;
        for (int c = 0; c < 5; c++) begin
            // dropping valid mid-transaction must not abort it
            if (c == 2) bus.dreq_valid = 1'b0;
            #1;
            checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 64'h100) begin errors++; $display("FAIL hold_addr[%0d]: got valid %0b addr %h expected 1 100", c, bus.mem_valid, bus.mem_addr); end
            tick();
        end
        bus.mem_data_ok = 1'b1;
        #1;
        checks++; if (bus.dresp_data_ok !== 1'b1) begin errors++; $display("FAIL hold_data_ok: got %0b expected 1", bus.dresp_data_ok); end
        tick();
        bus.mem_data_ok = 1'b0;
        $display("payload_hold: addr held 100 for 5 cycles");
    endtask

    task automatic test_reset_busy();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h40;
        tick();
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rstb_busy: got %0b expected 1", bus.mem_valid); end
        bus.ireq_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 64'hABCD;
        #1;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rstb_valid_drop: got %0b expected 0", bus.mem_valid); end
        checks++; if (bus.iresp_data_ok !== 1'b0 || bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL rstb_late_ok: got i=%0b d=%0b expected 0/0", bus.iresp_data_ok, bus.dresp_data_ok); end
        checks++; if (bus.mem_addr !== 64'h0) begin errors++; $display("FAIL rstb_addr_cleared: got %h expected 0", bus.mem_addr); end
        tick();
        bus.mem_data_ok = 1'b0;
        #1;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rstb_stays_idle: got %0b expected 0", bus.mem_valid); end
        $display("reset_busy: done");
    endtask

    task automatic test_spurious();
        bus.mem_data_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.mem_valid !== 1'b0 || bus.iresp_data_ok !== 1'b0 || bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL spur_idle[%0d]: got valid %0b i=%0b d=%0b expected 0/0/0", c, bus.mem_valid, bus.iresp_data_ok, bus.dresp_data_ok); end
            tick();
        end
        // stray mem_data_ok coinciding with a new grant in IDLE
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h88;
        #1;
        checks++; if (bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL spur_grant_ok: got %0b expected 0", bus.iresp_data_ok); end
        tick();
        bus.mem_data_ok = 1'b0;
        #1;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 64'h88) begin errors++; $display("FAIL spur_grant: got valid %0b addr %h expected 1 88", bus.mem_valid, bus.mem_addr); end
        tick();
        bus.mem_data_ok = 1'b1;
        bus.ireq_valid  = 1'b0;
        #1;
        checks++; if (bus.iresp_data_ok !== 1'b1) begin errors++; $display("FAIL spur_complete: got %0b expected 1", bus.iresp_data_ok); end
        tick();
        bus.mem_data_ok = 1'b0;
        $display("spurious: done");
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.ireq_valid  = 1'b0;
        bus.ireq_addr   = '0;
        bus.dreq_valid  = 1'b0;
        bus.dreq_addr   = '0;
        bus.dreq_size   = '0;
        bus.dreq_strobe = '0;
        bus.dreq_wdata  = '0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;

        test_reset();
        test_fetch();
        test_data_write();
        test_round_robin();
        test_payload_hold();
        test_reset_busy();
        test_spurious();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
